// File: rtl/booth_product_accum_if.sv
// ---------------------------------------------------------------------------
// booth_product_accum_if
//   Bundles the two handshakes of the product accumulator: the incoming
//   product stream from the Booth multiplier and the outgoing dot-product
//   result stream.
//
//   Signals
//     prod_valid  producer -> accumulator  prod_data is valid
//     prod_ready  accumulator -> producer  product accepted this cycle
//     prod_data   producer -> accumulator  signed PROD_W product
//     acc_valid   accumulator -> consumer  acc_data holds a completed result
//     acc_ready   consumer -> accumulator  consumer takes the result
//     acc_data    accumulator -> consumer  signed ACC_W saturated sum
//     acc_ovf     accumulator -> consumer  saturation hit during this result
//     term_cnt    accumulator -> consumer  products in the current sum
//
//   Modports
//     master  the environment: drives products, consumes results
//     slave   the accumulator itself
// ---------------------------------------------------------------------------
interface booth_product_accum_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int TERMS  = 8
);
    localparam int CNT_W = $clog2(TERMS + 1);

    logic                     prod_valid;
    logic                     prod_ready;
    logic signed [PROD_W-1:0] prod_data;
    logic                     acc_valid;
    logic                     acc_ready;
    logic signed [ACC_W-1:0]  acc_data;
    logic                     acc_ovf;
    logic [CNT_W-1:0]         term_cnt;

    modport master (
        output prod_valid,
        output prod_data,
        output acc_ready,
        input  prod_ready,
        input  acc_valid,
        input  acc_data,
        input  acc_ovf,
        input  term_cnt
    );

    modport slave (
        input  prod_valid,
        input  prod_data,
        input  acc_ready,
        output prod_ready,
        output acc_valid,
        output acc_data,
        output acc_ovf,
        output term_cnt
    );
endinterface

// File: rtl/booth_product_accum.sv
// ---------------------------------------------------------------------------
// booth_product_accum
//   Multiply-accumulate back end for the 16x16 signed Booth multiplier.
//   Sums TERMS signed products into a wider saturating accumulator, then
//   offers the result on a valid/ready handshake and restarts once it has
//   been taken.
//
//   Ports
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     clear  in  synchronous abort: drop the partial sum or pending result
//     bus    slave side of booth_product_accum_if
//              prod_valid/prod_ready/prod_data  product stream in
//              acc_valid/acc_ready/acc_data     result stream out
//              acc_ovf                          sticky saturation flag
//              term_cnt                         products in current sum
// ---------------------------------------------------------------------------
module booth_product_accum #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int TERMS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    booth_product_accum_if.slave  bus
);
    localparam int CNT_W = $clog2(TERMS + 1);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(TERMS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Two same-signed operands whose sum flips sign have overflowed.
    function automatic logic add_ovf(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b,
        input logic signed [ACC_W-1:0] s
    );
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    // Saturating add: clamps to the rail in the direction of the operands.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W-1:0] s;
        s = a + b;
        if (add_ovf(a, b, s)) begin
            return a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
        return s;
    endfunction

    state_t                  state, state_nx;
    logic signed [ACC_W-1:0] acc_p1, acc_nx;
    logic                    ovf_p1, ovf_nx;
    logic [CNT_W-1:0]        cnt_p1, cnt_nx;

    logic signed [ACC_W-1:0] prod_ext_p0;
    logic signed [ACC_W-1:0] sum_raw_p0;
    logic signed [ACC_W-1:0] sum_sat_p0;
    logic                    sum_ovf_p0;
    logic                    ready;
    logic                    accept;

    // Stage p0: widen the incoming product and form the candidate sum.
    assign prod_ext_p0 = {{(ACC_W-PROD_W){bus.prod_data[PROD_W-1]}}, bus.prod_data};
    assign sum_raw_p0  = acc_p1 + prod_ext_p0;
    assign sum_ovf_p0  = add_ovf(acc_p1, prod_ext_p0, sum_raw_p0);
    assign sum_sat_p0  = sat_add(acc_p1, prod_ext_p0);

    // rst_n gates ready so nothing looks accepted while reset is held.
    assign ready  = rst_n && (state == ACCUM) && !clear;
    assign accept = ready && bus.prod_valid;

    always_comb begin
        state_nx = state;
        acc_nx   = acc_p1;
        ovf_nx   = ovf_p1;
        cnt_nx   = cnt_p1;

        if (clear) begin
            // Abort wins over both an offered product and a result handoff.
            state_nx = ACCUM;
            acc_nx   = '0;
            ovf_nx   = 1'b0;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        acc_nx = sum_sat_p0;
                        ovf_nx = ovf_p1 | sum_ovf_p0;
                        cnt_nx = cnt_p1 + CNT_W'(1);
                        if (cnt_p1 == LAST_CNT) begin
                            state_nx = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.acc_ready) begin
                        state_nx = ACCUM;
                        acc_nx   = '0;
                        ovf_nx   = 1'b0;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = ACCUM;
                end
            endcase
        end
    end

    // Stage p1: accumulator, flag, count and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ACCUM;
            acc_p1 <= '0;
            ovf_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            state  <= state_nx;
            acc_p1 <= acc_nx;
            ovf_p1 <= ovf_nx;
            cnt_p1 <= cnt_nx;
        end
    end

    assign bus.prod_ready = ready;
    assign bus.acc_valid  = (state == HOLD);
    assign bus.acc_data   = acc_p1;
    assign bus.acc_ovf    = ovf_p1;
    assign bus.term_cnt   = cnt_p1;

endmodule

// File: tb/tb_booth_product_accum.sv
module tb_booth_product_accum;

    localparam int TA = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        pv;
    logic [31:0] pd;
    logic        ar;
    logic        pv_c;
    logic [31:0] pd_c;
    logic        ar_c;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_product_accum_if #(.PROD_W(32), .ACC_W(40), .TERMS(TA)) ia ();
    booth_product_accum_if #(.PROD_W(32), .ACC_W(33), .TERMS(TA)) ib ();
    booth_product_accum_if #(.PROD_W(32), .ACC_W(40), .TERMS(1))  ic ();

    assign ia.prod_valid = pv;
    assign ia.prod_data  = pd;
    assign ia.acc_ready  = ar;
    assign ib.prod_valid = pv;
    assign ib.prod_data  = pd;
    assign ib.acc_ready  = ar;
    assign ic.prod_valid = pv_c;
    assign ic.prod_data  = pd_c;
    assign ic.acc_ready  = ar_c;

    booth_product_accum #(.PROD_W(32), .ACC_W(40), .TERMS(TA)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clr), .bus(ia.slave));
    booth_product_accum #(.PROD_W(32), .ACC_W(33), .TERMS(TA)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clr), .bus(ib.slave));
    booth_product_accum #(.PROD_W(32), .ACC_W(40), .TERMS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .bus(ic.slave));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of dut_a: running sum clamped to the 40-bit range
    // after every accepted product, sticky flag, count, and a result-pending
    // flag. Updated on the clock edge from the inputs the bench is applying.
    localparam longint AMAX = (64'sd1 <<< 39) - 1;
    localparam longint AMIN = -(64'sd1 <<< 39);

    longint m_acc = 0;
    bit     m_ovf = 0;
    bit     m_hold = 0;
    int     m_cnt = 0;

    function automatic longint clamp40(input longint s);
        if (s > AMAX) return AMAX;
        if (s < AMIN) return AMIN;
        return s;
    endfunction

    function automatic bit out40(input longint s);
        return (s > AMAX) || (s < AMIN);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr || (m_hold && ar)) begin
            m_acc  <= 0;
            m_ovf  <= 0;
            m_hold <= 0;
            m_cnt  <= 0;
        end else if (!m_hold && pv) begin
            m_acc <= clamp40(m_acc + longint'(signed'(pd)));
            m_ovf <= m_ovf | out40(m_acc + longint'(signed'(pd)));
            m_cnt <= m_cnt + 1;
            if (m_cnt == TA - 1) m_hold <= 1;
        end
    end

    logic [39:0] m_acc40;
    assign m_acc40 = m_acc[39:0];

    // Cycle-by-cycle check of dut_a against the model.
    always @(negedge clk) begin
        chk("a_prod_ready", ia.prod_ready, rst_n && !m_hold && !clr);
        chk("a_acc_valid", ia.acc_valid, m_hold);
        chk("a_term_cnt", ia.term_cnt, m_cnt);
        chk("a_acc_data", $unsigned(ia.acc_data), m_acc40);
        chk("a_acc_ovf", ia.acc_ovf, m_ovf);
    end

    task automatic push(input logic [31:0] d);
        logic rdy;
        rdy = 1'b0;
        pv = 1'b1;
        pd = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = ia.prod_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
        end
        chk("push_accept", rdy, 1'b1);
        pv = 1'b0;
    endtask

    task automatic push_seq(input logic [31:0] first, input logic [31:0] step);
        for (int i = 0; i < TA; i++) push(first + step * i);
    endtask

    task automatic wait_result();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ia.acc_valid) break;
        end
        chk("result_wait", ia.acc_valid, 1'b1);
    endtask

    task automatic deliver();
        @(posedge clk);
        #1 ar = 1'b1;
        @(posedge clk);
        #1 ar = 1'b0;
    endtask

    initial begin
        int start;
        rst_n = 1'b0;
        clr = 1'b0; pv = 1'b0; pd = '0; ar = 1'b0;
        pv_c = 1'b0; pd_c = '0; ar_c = 1'b0;

        // Reset state and release between edges.
        repeat (3) @(posedge clk);
        #3;
        chk("rst_prod_ready", ia.prod_ready, 1'b0);
        chk("rst_acc_valid", ia.acc_valid, 1'b0);
        chk("rst_acc_data", $unsigned(ia.acc_data), 40'h0);
        chk("rst_term_cnt", ia.term_cnt, 4'd0);
        rst_n = 1'b1;
        #1 chk("rel_prod_ready", ia.prod_ready, 1'b1);
        @(posedge clk);
        #1;

        // Products 1..8 back to back.
        start = cyc;
        push_seq(32'd1, 32'd1);
        chk("b2b_cycles", cyc - start, TA);
        wait_result();
        chk("latency", cyc - start, TA);
        chk("sum36_data", $unsigned(ia.acc_data), 40'd36);
        chk("sum36_ovf", ia.acc_ovf, 1'b0);
        chk("sum36_cnt", ia.term_cnt, 4'd8);
        chk("sum36_b", $unsigned(ib.acc_data), 33'd36);
        deliver();

        // Mixed signs: -10 + 25 + (-32768*32767) + five zeros.
        push(32'hFFFF_FFF6);
        push(32'd25);
        push(32'hC000_8000);
        for (int i = 0; i < 5; i++) push(32'd0);
        wait_result();
        chk("mixed_data", $unsigned(ia.acc_data), 40'hFF_C000_800F);
        chk("mixed_ovf", ia.acc_ovf, 1'b0);
        deliver();

        // Backpressure with a product offered during HOLD and the handoff.
        push_seq(32'd10, 32'd10);
        wait_result();
        @(posedge clk);
        #1 pv = 1'b1;
        pd = 32'd1000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_data", $unsigned(ia.acc_data), 40'd360);
            chk("bp_ready", ia.prod_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        ar = 1'b1;
        @(posedge clk);
        #1 ar = 1'b0;
        pv = 1'b0;
        @(negedge clk);
        chk("handoff_cnt", ia.term_cnt, 4'd0);
        chk("handoff_valid", ia.acc_valid, 1'b0);
        @(posedge clk);
        #1;

        // Saturation on the 33-bit instance; 40-bit instance does not clip.
        push_seq(32'h7FFF_FFFF, 32'd0);
        wait_result();
        chk("sat_b_data", $unsigned(ib.acc_data), 33'h0_FFFF_FFFF);
        chk("sat_b_ovf", ib.acc_ovf, 1'b1);
        chk("sat_a_data", $unsigned(ia.acc_data), 40'h3_FFFF_FFF8);
        deliver();
        push_seq(32'd1, 32'd1);
        wait_result();
        chk("after_sat_b_data", $unsigned(ib.acc_data), 33'd36);
        chk("after_sat_b_ovf", ib.acc_ovf, 1'b0);
        deliver();

        // clear after 3 accepts, with a product offered.
        push(32'd5); push(32'd6); push(32'd7);
        clr = 1'b1;
        pv = 1'b1;
        pd = 32'd99;
        @(negedge clk);
        chk("clr_ready", ia.prod_ready, 1'b0);
        @(posedge clk);
        #1 clr = 1'b0;
        pv = 1'b0;
        @(negedge clk);
        chk("clr_cnt", ia.term_cnt, 4'd0);
        chk("clr_data", $unsigned(ia.acc_data), 40'd0);
        @(posedge clk);
        #1;
        push_seq(32'd1, 32'd1);
        wait_result();
        chk("post_clr_data", $unsigned(ia.acc_data), 40'd36);
        deliver();

        // clear during HOLD beats acc_ready.
        push_seq(32'd2, 32'd0);
        wait_result();
        @(posedge clk);
        #1 clr = 1'b1;
        ar = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        ar = 1'b0;
        @(negedge clk);
        chk("clr_hold_valid", ia.acc_valid, 1'b0);
        chk("clr_hold_cnt", ia.term_cnt, 4'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-sum, mid-clock.
        push(32'd3); push(32'd4); push(32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", $unsigned(ia.acc_data), 40'd0);
        chk("arst_cnt", ia.term_cnt, 4'd0);
        chk("arst_ready", ia.prod_ready, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_seq(32'd1, 32'd1);
        wait_result();
        chk("post_rst_data", $unsigned(ia.acc_data), 40'd36);
        deliver();

        // TERMS=1 instance: every product is a complete result.
        pv_c = 1'b1;
        pd_c = 32'hFFFF_FFF9;
        @(negedge clk);
        chk("t1_ready", ic.prod_ready, 1'b1);
        @(posedge clk);
        #1 pv_c = 1'b0;
        @(negedge clk);
        chk("t1_valid", ic.acc_valid, 1'b1);
        chk("t1_data", $unsigned(ic.acc_data), 40'hFF_FFFF_FFF9);
        chk("t1_cnt", ic.term_cnt, 1'b1);
        chk("t1_hold_ready", ic.prod_ready, 1'b0);
        @(posedge clk);
        #1 ar_c = 1'b1;
        @(posedge clk);
        #1 ar_c = 1'b0;
        @(negedge clk);
        chk("t1_done_valid", ic.acc_valid, 1'b0);
        chk("t1_done_cnt", ic.term_cnt, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
